// File: rtl/uart_sram_loader.sv
// uart_sram_loader
//   Receives 8N1 UART bytes (LSB first) on a single RX pin, packs each pair of
//   bytes into a 16-bit word (first byte in the high half), and writes the
//   words to sequential SRAM addresses with a one-clock active-low strobe.
//
// Ports:
//   Clock           in   system clock, rising edge
//   Reset           in   synchronous active-high reset
//   UART_RX_I       in   serial input, idles high, asynchronous to Clock
//   Initialize      in   synchronous restart of address, byte phase, error
//   Enable          in   reception enable; 0 holds the receiver idle
//   SRAM_address    out  word address of the current/next write
//   SRAM_write_data out  packed word being written
//   SRAM_we_n       out  active-low write strobe, one clock wide
//   Frame_error     out  sticky: a stop bit was sampled low
module uart_sram_loader #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  UART_RX_I,
    input  logic                  Initialize,
    input  logic                  Enable,
    output logic [ADDR_WIDTH-1:0] SRAM_address,
    output logic [DATA_WIDTH-1:0] SRAM_write_data,
    output logic                  SRAM_we_n,
    output logic                  Frame_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    // Terminal counts: a counter that started at 0 reaches these after
    // exactly CLKS_PER_BIT (or CLKS_PER_BIT/2) clocks.
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Two-flop synchronizer for the asynchronous RX pin.
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX_I;
            rx_sync_q <= rx_meta_q;
        end
    end

    rx_state_t             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            bit_idx_q;
    logic [7:0]            shift_q;
    logic                  phase_high_q;   // 1: next valid byte goes to [15:8]
    logic                  strobe_pend_q;  // word complete, strobe next cycle
    logic                  we_n_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  frame_err_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            phase_high_q  <= 1'b1;
            strobe_pend_q <= 1'b0;
            we_n_q        <= 1'b1;
            addr_q        <= '0;
            data_q        <= '0;
            frame_err_q   <= 1'b0;
        end else if (Initialize) begin
            // Data word deliberately left untouched.
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            phase_high_q  <= 1'b1;
            strobe_pend_q <= 1'b0;
            we_n_q        <= 1'b1;
            addr_q        <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            // Write sequencing: data lands on cycle N, strobe on N+1,
            // address advances on N+2. Runs regardless of Enable so a
            // completed word is never lost.
            we_n_q <= 1'b1;
            if (strobe_pend_q) begin
                we_n_q        <= 1'b0;
                strobe_pend_q <= 1'b0;
            end
            if (!we_n_q) begin
                addr_q <= addr_q + ADDR_ONE;
            end

            if (!Enable) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q <= '0;
                        if (!rx_sync_q) begin
                            state_q <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (cnt_q == HALF_LAST) begin
                            cnt_q <= '0;
                            if (!rx_sync_q) begin
                                state_q   <= ST_DATA;
                                bit_idx_q <= '0;
                            end else begin
                                state_q <= ST_IDLE;  // glitch, not a start bit
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_q == FULL_LAST) begin
                            cnt_q   <= '0;
                            shift_q <= {rx_sync_q, shift_q[7:1]};  // LSB first
                            if (bit_idx_q == 3'd7) begin
                                state_q <= ST_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (cnt_q == FULL_LAST) begin
                            // Leave mid-stop-bit so an immediately following
                            // start bit is caught.
                            cnt_q   <= '0;
                            state_q <= ST_IDLE;
                            if (rx_sync_q) begin
                                if (phase_high_q) begin
                                    data_q[DATA_WIDTH-1 -: 8] <= shift_q;
                                    phase_high_q              <= 1'b0;
                                end else begin
                                    data_q[7:0]   <= shift_q;
                                    phase_high_q  <= 1'b1;
                                    strobe_pend_q <= 1'b1;
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = data_q;
    assign SRAM_we_n       = we_n_q;
    assign Frame_error     = frame_err_q;

endmodule

// File: tb/tb_uart_sram_loader.sv
module tb_uart_sram_loader;

    localparam int CLKS = 16;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        rx   = 1'b1;
    logic        init = 1'b0;
    logic        en   = 1'b1;
    logic [17:0] sram_addr;
    logic [15:0] sram_data;
    logic        sram_we_n;
    logic        frame_err;

    uart_sram_loader #(
        .CLK_FREQ_HZ(1600000),
        .BAUD_RATE  (100000),
        .ADDR_WIDTH (18),
        .DATA_WIDTH (16)
    ) dut (
        .Clock          (clk),
        .Reset          (rst),
        .UART_RX_I      (rx),
        .Initialize     (init),
        .Enable         (en),
        .SRAM_address   (sram_addr),
        .SRAM_write_data(sram_data),
        .SRAM_we_n      (sram_we_n),
        .Frame_error    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  got_mark = 0;
    int  exp_mark = 0;
    int  checks   = 0;
    int  errors   = 0;
    int  pulse_err = 0;
    int  low_run   = 0;

    // Behavioural model: a byte stream packed high-then-low into words.
    logic [17:0] m_addr = '0;
    logic        m_high = 1'b1;
    logic [7:0]  m_hi   = '0;
    logic        m_err  = 1'b0;

    // Strobe monitor: captures every write and flags strobes wider than 1.
    always @(negedge clk) begin
        if (!rst && !sram_we_n) begin
            got_q.push_back('{a: sram_addr, d: sram_data});
            low_run++;
            if (low_run == 2) pulse_err++;
        end else begin
            low_run = 0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_high) begin
            m_hi   = b;
            m_high = 1'b0;
        end else begin
            exp_q.push_back('{a: m_addr, d: {m_hi, b}});
            m_addr = m_addr + 18'd1;
            m_high = 1'b1;
        end
    endtask

    // counted=0 means the receiver is expected to ignore this frame.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic counted);
        rx = 1'b0;
        tick(CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CLKS);
        end
        rx = stop_ok;
        tick(CLKS);
        rx = 1'b1;
        if (counted) begin
            if (stop_ok) model_byte(b);
            else         m_err = 1'b1;
        end
    endtask

    task automatic do_init();
        init = 1'b1;
        tick(1);
        init = 1'b0;
        m_addr = '0;
        m_high = 1'b1;
        m_err  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++;
        if (sram_addr !== 18'd0) begin
            errors++; $display("FAIL reset_addr: got %0d required 0", sram_addr);
        end
        checks++;
        if (sram_we_n !== 1'b1) begin
            errors++; $display("FAIL reset_we_n: got %b required 1", sram_we_n);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_frame_err: got %b required 0", frame_err);
        end
        checks++;
        if (sram_data !== 16'h0000) begin
            errors++; $display("FAIL reset_data: got %h required 0000", sram_data);
        end
        $display("test_reset: addr=%0d we_n=%b err=%b", sram_addr, sram_we_n, frame_err);
    endtask

    task automatic test_two_bytes();
        int pe;
        do_init();
        pe = pulse_err;
        send_byte(8'hAB, 1'b1, 1'b1);
        send_byte(8'hCD, 1'b1, 1'b1);
        tick(6);
        checks++;
        if (got_q.size() - got_mark !== 1) begin
            errors++; $display("FAIL two_bytes_count: got %0d writes required 1", got_q.size() - got_mark);
        end else begin
            checks++;
            if (got_q[got_mark] !== {18'd0, 16'hABCD}) begin
                errors++; $display("FAIL two_bytes_write: got %h@%0d required abcd@0",
                                   got_q[got_mark].d, got_q[got_mark].a);
            end
        end
        checks++;
        if (pulse_err !== pe) begin
            errors++; $display("FAIL two_bytes_pulse_width: got %0d wide pulses required 0", pulse_err - pe);
        end
        checks++;
        if (sram_addr !== 18'd1) begin
            errors++; $display("FAIL two_bytes_addr: got %0d required 1", sram_addr);
        end
        $display("test_two_bytes: writes=%0d addr=%0d", got_q.size() - got_mark, sram_addr);
        got_mark = got_q.size();
        exp_mark = exp_q.size();
    endtask

    task automatic test_back_to_back();
        int pe;
        do_init();
        pe = pulse_err;
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1, 1'b1);
        tick(6);
        checks++;
        if (got_q.size() - got_mark !== exp_q.size() - exp_mark) begin
            errors++; $display("FAIL b2b_count: got %0d writes required %0d",
                               got_q.size() - got_mark, exp_q.size() - exp_mark);
        end else begin
            for (int i = 0; i < exp_q.size() - exp_mark; i++) begin
                checks++;
                if (got_q[got_mark+i] !== exp_q[exp_mark+i]) begin
                    errors++; $display("FAIL b2b_write%0d: got %h@%0d required %h@%0d", i,
                                       got_q[got_mark+i].d, got_q[got_mark+i].a,
                                       exp_q[exp_mark+i].d, exp_q[exp_mark+i].a);
                end
            end
        end
        checks++;
        if (pulse_err !== pe) begin
            errors++; $display("FAIL b2b_pulse_width: got %0d wide pulses required 0", pulse_err - pe);
        end
        checks++;
        if (sram_addr !== 18'd3) begin
            errors++; $display("FAIL b2b_addr: got %0d required 3", sram_addr);
        end
        $display("test_back_to_back: writes=%0d addr=%0d", got_q.size() - got_mark, sram_addr);
        got_mark = got_q.size();
        exp_mark = exp_q.size();
    endtask

    task automatic test_frame_error();
        do_init();
        send_byte(8'h55, 1'b0, 1'b1);
        tick(3 * CLKS);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++; $display("FAIL ferr_set: got %b required 1", frame_err);
        end
        send_byte(8'h12, 1'b1, 1'b1);
        send_byte(8'h34, 1'b1, 1'b1);
        tick(6);
        checks++;
        if (frame_err !== m_err) begin
            errors++; $display("FAIL ferr_sticky: got %b required %b", frame_err, m_err);
        end
        checks++;
        if (got_q.size() - got_mark !== 1) begin
            errors++; $display("FAIL ferr_count: got %0d writes required 1", got_q.size() - got_mark);
        end else begin
            checks++;
            if (got_q[got_mark] !== {18'd0, 16'h1234}) begin
                errors++; $display("FAIL ferr_write: got %h@%0d required 1234@0",
                                   got_q[got_mark].d, got_q[got_mark].a);
            end
        end
        $display("test_frame_error: err=%b writes=%0d", frame_err, got_q.size() - got_mark);
        got_mark = got_q.size();
        exp_mark = exp_q.size();
    endtask

    task automatic test_glitch();
        do_init();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * CLKS);
        send_byte(8'hAA, 1'b1, 1'b1);
        send_byte(8'hBB, 1'b1, 1'b1);
        tick(6);
        checks++;
        if (got_q.size() - got_mark !== 1) begin
            errors++; $display("FAIL glitch_count: got %0d writes required 1", got_q.size() - got_mark);
        end else begin
            checks++;
            if (got_q[got_mark] !== {18'd0, 16'hAABB}) begin
                errors++; $display("FAIL glitch_write: got %h@%0d required aabb@0",
                                   got_q[got_mark].d, got_q[got_mark].a);
            end
        end
        $display("test_glitch: writes=%0d addr=%0d", got_q.size() - got_mark, sram_addr);
        got_mark = got_q.size();
        exp_mark = exp_q.size();
    endtask

    task automatic test_initialize();
        do_init();
        send_byte(8'h99, 1'b0, 1'b1);   // leave a frame error behind
        tick(3 * CLKS);
        send_byte(8'h11, 1'b1, 1'b1);
        tick(5);
        do_init();
        send_byte(8'h22, 1'b1, 1'b1);
        send_byte(8'h33, 1'b1, 1'b1);
        tick(6);
        checks++;
        if (got_q.size() - got_mark !== 1) begin
            errors++; $display("FAIL init_count: got %0d writes required 1", got_q.size() - got_mark);
        end else begin
            checks++;
            if (got_q[got_mark] !== {18'd0, 16'h2233}) begin
                errors++; $display("FAIL init_write: got %h@%0d required 2233@0",
                                   got_q[got_mark].d, got_q[got_mark].a);
            end
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL init_ferr: got %b required 0", frame_err);
        end
        $display("test_initialize: writes=%0d err=%b", got_q.size() - got_mark, frame_err);
        got_mark = got_q.size();
        exp_mark = exp_q.size();
    endtask

    task automatic test_enable();
        logic [17:0] addr_before;
        do_init();
        send_byte(8'h10, 1'b1, 1'b1);
        send_byte(8'h20, 1'b1, 1'b1);
        send_byte(8'h77, 1'b1, 1'b1);   // phase now LOW, address 1
        tick(6);
        addr_before = sram_addr;
        got_mark = got_q.size();
        exp_mark = exp_q.size();
        en = 1'b0;
        send_byte(8'h44, 1'b1, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        tick(6);
        checks++;
        if (got_q.size() - got_mark !== 0) begin
            errors++; $display("FAIL enable_writes: got %0d writes required 0", got_q.size() - got_mark);
        end
        checks++;
        if (sram_addr !== m_addr) begin
            errors++; $display("FAIL enable_addr: got %0d required %0d (was %0d)", sram_addr, m_addr, addr_before);
        end
        en = 1'b1;
        tick(4);
        send_byte(8'h88, 1'b1, 1'b1);   // completes 0x7788 at retained address
        tick(6);
        checks++;
        if (got_q.size() - got_mark !== 1) begin
            errors++; $display("FAIL enable_resume_count: got %0d writes required 1", got_q.size() - got_mark);
        end else begin
            checks++;
            if (got_q[got_mark] !== exp_q[exp_mark]) begin
                errors++; $display("FAIL enable_resume_write: got %h@%0d required %h@%0d",
                                   got_q[got_mark].d, got_q[got_mark].a,
                                   exp_q[exp_mark].d, exp_q[exp_mark].a);
            end
        end
        $display("test_enable: writes=%0d addr=%0d", got_q.size() - got_mark, sram_addr);
        got_mark = got_q.size();
        exp_mark = exp_q.size();
    endtask

    task automatic test_random();
        int pe;
        logic [7:0] b;
        logic       ok;
        do_init();
        pe = pulse_err;
        for (int n = 0; n < 14; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_byte(b, ok, 1'b1);
            if (!ok) tick(3 * CLKS);
            else     tick($urandom_range(0, 20));
        end
        tick(6);
        checks++;
        if (got_q.size() - got_mark !== exp_q.size() - exp_mark) begin
            errors++; $display("FAIL rand_count: got %0d writes required %0d",
                               got_q.size() - got_mark, exp_q.size() - exp_mark);
        end else begin
            for (int i = 0; i < exp_q.size() - exp_mark; i++) begin
                checks++;
                if (got_q[got_mark+i] !== exp_q[exp_mark+i]) begin
                    errors++; $display("FAIL rand_write%0d: got %h@%0d required %h@%0d", i,
                                       got_q[got_mark+i].d, got_q[got_mark+i].a,
                                       exp_q[exp_mark+i].d, exp_q[exp_mark+i].a);
                end
            end
        end
        checks++;
        if (sram_addr !== m_addr) begin
            errors++; $display("FAIL rand_addr: got %0d required %0d", sram_addr, m_addr);
        end
        checks++;
        if (frame_err !== m_err) begin
            errors++; $display("FAIL rand_ferr: got %b required %b", frame_err, m_err);
        end
        checks++;
        if (pulse_err !== pe) begin
            errors++; $display("FAIL rand_pulse_width: got %0d wide pulses required 0", pulse_err - pe);
        end
        $display("test_random: writes=%0d addr=%0d err=%b", got_q.size() - got_mark, sram_addr, frame_err);
        got_mark = got_q.size();
        exp_mark = exp_q.size();
    endtask

    initial begin
        test_reset();
        test_two_bytes();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_initialize();
        test_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
